// File: rtl/riscv_lite_datapath.sv
// riscv_lite_datapath
//   Single-cycle RV32I-subset core with an on-chip instruction ROM and data RAM.
//   One instruction retires per rising edge while EN=1, START=1, RSTn=0 and the
//   core has not halted. Fetching JAL x0,0 or ECALL halts the core and raises OK.
//   The DDR3 pins are parked: NOP command, clock running, power-down, bus high-Z.
//
// Ports
//   CLK            clock, rising-edge
//   RSTn           synchronous reset, active HIGH despite the name
//   EN             global enable; 0 freezes PC, register file and RAM
//   START          run request, qualified by EN
//   OK             sticky halt flag, cleared only by reset
//   ddr3_*         DDR3 pin interface, static idle except ck_p/ck_n and reset_n
module riscv_lite_datapath #(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter string       IMEM_FILE  = "main_hex.txt",
  parameter string       DMEM_FILE  = "data_hex.txt",
  parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
  parameter int          DQ_WIDTH   = 8,
  parameter int          ROW_WIDTH  = 15,
  parameter int          BA_WIDTH   = 3
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 EN,
  input  logic                 START,
  output logic                 OK,
  output logic                 ddr3_reset_n,
  output logic                 ddr3_ck_p,
  output logic                 ddr3_ck_n,
  output logic                 ddr3_cke,
  output logic                 ddr3_ras_n,
  output logic                 ddr3_cas_n,
  output logic                 ddr3_we_n,
  output logic [BA_WIDTH-1:0]  ddr3_ba,
  output logic [ROW_WIDTH-1:0] ddr3_addr,
  output logic                 ddr3_dm,
  output logic                 ddr3_odt,
  inout  wire  [DQ_WIDTH-1:0]  ddr3_dq,
  inout  wire                  ddr3_dqs_p,
  inout  wire                  ddr3_dqs_n
);

  localparam int          IA         = $clog2(IMEM_WORDS);
  localparam int          DA         = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] regs [32];
  logic [31:0] pc;

  logic [31:0]        instr, rs1_v, rs2_v, pc_plus4, next_pc, wb;
  logic [31:0]        daddr, doff, ld_data;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0]         opc, f7;
  logic [4:0]         rd, rs1, rs2;
  logic [2:0]         f3;
  logic               wen, st_en, halt, exec, d_in_rng, br_taken, r_ok, i_ok;

  function automatic logic [31:0] alu(input logic [2:0] fn, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] y;
    case (fn)
      3'b000:  y = alt ? a - b : a + b;
      3'b001:  y = a << b[4:0];
      3'b010:  y = {31'b0, $signed(a) < $signed(b)};
      3'b100:  y = a ^ b;
      3'b101:  y = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  y = a | b;
      3'b111:  y = a & b;
      default: y = '0;
    endcase
    return y;
  endfunction

  assign instr = imem[pc[IA+1:2]];
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign f7    = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // x0 is forced to zero on read so it is correct even before the first reset.
  assign rs1_v    = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_v    = (rs2 == 5'd0) ? '0 : regs[rs2];
  assign pc_plus4 = pc + 32'd4;

  assign halt = (instr == 32'h0000_006F) || (instr == 32'h0000_0073);
  assign exec = EN && START && !RSTn && !OK;

  // A single unsigned compare on the rebased address also rejects addresses below the base.
  assign daddr    = rs1_v + $unsigned((opc == OP_STORE) ? imm_s : imm_i);
  assign doff     = daddr - DMEM_BASE;
  assign d_in_rng = doff < DMEM_BYTES;
  assign ld_data  = d_in_rng ? dmem[doff[DA+1:2]] : '0;

  // Only the listed R-type and OP-IMM encodings are accepted; any other encoding is a NOP.
  assign r_ok = (f3 != 3'b011) &&
                ((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
  assign i_ok = (f3 != 3'b011) &&
                ((f3 != 3'b001) || (f7 == 7'h00)) &&
                ((f3 != 3'b101) || (f7 == 7'h00) || (f7 == 7'h20));

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:  br_taken = (rs1_v == rs2_v);
      3'b001:  br_taken = (rs1_v != rs2_v);
      3'b100:  br_taken = ($signed(rs1_v) < $signed(rs2_v));
      3'b101:  br_taken = ($signed(rs1_v) >= $signed(rs2_v));
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = pc_plus4;
    wb      = '0;
    wen     = 1'b0;
    st_en   = 1'b0;
    case (opc)
      OP_REG: if (r_ok) begin
        wen = 1'b1;
        wb  = alu(f3, f7[5], rs1_v, rs2_v);
      end
      OP_IMM: if (i_ok) begin
        // Only the shift-right group uses funct7 as an arithmetic select; for ADDI it is immediate.
        wen = 1'b1;
        wb  = alu(f3, (f3 == 3'b101) && f7[5], rs1_v, $unsigned(imm_i));
      end
      OP_LOAD: if (f3 == 3'b010) begin
        wen = 1'b1;
        wb  = ld_data;
      end
      OP_STORE:  st_en = (f3 == 3'b010);
      OP_BRANCH: if (br_taken) next_pc = pc + $unsigned(imm_b);
      OP_LUI: begin
        wen = 1'b1;
        wb  = $unsigned(imm_u);
      end
      OP_AUIPC: begin
        wen = 1'b1;
        wb  = pc + $unsigned(imm_u);
      end
      OP_JAL: begin
        wen     = 1'b1;
        wb      = pc_plus4;
        next_pc = pc + $unsigned(imm_j);
      end
      OP_JALR: if (f3 == 3'b000) begin
        wen     = 1'b1;
        wb      = pc_plus4;
        next_pc = (rs1_v + $unsigned(imm_i)) & ~32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RSTn) begin
      pc           <= '0;
      OK           <= 1'b0;
      ddr3_reset_n <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      ddr3_reset_n <= 1'b1;
      if (exec) begin
        // The halt word only raises OK; PC and registers stay put.
        if (halt) begin
          OK <= 1'b1;
        end else begin
          pc <= next_pc;
          if (wen && (rd != 5'd0)) regs[rd] <= wb;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (exec && !halt && st_en && d_in_rng) dmem[doff[DA+1:2]] <= rs2_v;
  end

  assign ddr3_ck_p  = CLK;
  assign ddr3_ck_n  = ~CLK;
  assign ddr3_cke   = 1'b0;
  assign ddr3_ras_n = 1'b1;
  assign ddr3_cas_n = 1'b1;
  assign ddr3_we_n  = 1'b1;
  assign ddr3_ba    = '0;
  assign ddr3_addr  = '0;
  assign ddr3_dm    = 1'b0;
  assign ddr3_odt   = 1'b0;
  assign ddr3_dq    = {DQ_WIDTH{1'bz}};
  assign ddr3_dqs_p = 1'bz;
  assign ddr3_dqs_n = 1'bz;

  logic unused_bits;
  assign unused_bits = ^doff[1:0];

endmodule

// File: tb/tb_riscv_lite_datapath.sv
// Bench for riscv_lite_datapath: loads small programs into the ROM, runs each to
// halt and compares architectural state against hand-derived expectations.
module tb_riscv_lite_datapath;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic        EN = 1'b0;
  logic        START = 1'b0;
  wire         OK, ddr3_reset_n, ddr3_ck_p, ddr3_ck_n, ddr3_cke;
  wire         ddr3_ras_n, ddr3_cas_n, ddr3_we_n, ddr3_dm, ddr3_odt;
  wire [2:0]   ddr3_ba;
  wire [14:0]  ddr3_addr;
  wire [7:0]   ddr3_dq;
  wire         ddr3_dqs_p, ddr3_dqs_n;

  localparam int K_REG = 0, K_PC = 1, K_MEM = 2, K_OK = 3, K_EDGES = 4;

  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] prog[$];
  int          checks = 0;
  int          errors = 0;
  int          last_edges = 0;

  riscv_lite_datapath #(.IMEM_FILE(""), .DMEM_FILE("")) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .START(START), .OK(OK),
    .ddr3_reset_n(ddr3_reset_n), .ddr3_ck_p(ddr3_ck_p), .ddr3_ck_n(ddr3_ck_n),
    .ddr3_cke(ddr3_cke), .ddr3_ras_n(ddr3_ras_n), .ddr3_cas_n(ddr3_cas_n),
    .ddr3_we_n(ddr3_we_n), .ddr3_ba(ddr3_ba), .ddr3_addr(ddr3_addr),
    .ddr3_dm(ddr3_dm), .ddr3_odt(ddr3_odt), .ddr3_dq(ddr3_dq),
    .ddr3_dqs_p(ddr3_dqs_p), .ddr3_dqs_n(ddr3_dqs_n)
  );

  always #5 CLK = ~CLK;

  wire unused_tb = ^{ddr3_dq, ddr3_dqs_p, ddr3_dqs_n};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd, int op);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, int op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic expect_val(input string tag, input int kind, input int idx, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.exp = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(int kind, int idx);
    case (kind)
      K_REG:   return dut.regs[idx];
      K_PC:    return dut.pc;
      K_MEM:   return dut.dmem[idx];
      K_OK:    return 32'(OK);
      default: return 32'(last_edges);
    endcase
  endfunction

  task automatic drain();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.kind, e.idx), e.exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) dut.imem[i] = prog[i];
  endtask

  task automatic do_reset(input string name);
    EN = 1'b0; START = 1'b0; RSTn = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check({name, ".rst_pc"}, dut.pc, 32'd0);
    check({name, ".rst_ok"}, 32'(OK), 32'd0);
    check({name, ".rst_x3"}, dut.regs[3], 32'd0);
    check({name, ".rst_x7"}, dut.regs[7], 32'd0);
    check({name, ".rst_ddr_rstn"}, 32'(ddr3_reset_n), 32'd0);
    check({name, ".rst_cmd"}, {29'd0, ddr3_ras_n, ddr3_cas_n, ddr3_we_n}, 32'd7);
    check({name, ".rst_static"}, {8'd0, ddr3_cke, ddr3_dm, ddr3_odt, ddr3_ba, ddr3_addr, 3'd0}, 32'd0);
  endtask

  // Runs from PC 0 until OK or the cycle budget expires; optionally freezes with EN=0
  // after stall_at enabled edges and checks PC / x7 against the given values.
  task automatic run(input string name, input int budget, input int stall_at, input int stall_len,
                     input logic [31:0] stall_pc, input logic [31:0] stall_x7);
    int  edges;
    bit  stalled;
    edges = 0;
    stalled = 0;
    RSTn = 1'b0; EN = 1'b1; START = 1'b1;
    for (int c = 0; c < budget && !OK; c++) begin
      if (!stalled && edges == stall_at) begin
        check({name, ".pre_stall_pc"}, dut.pc, stall_pc);
        check({name, ".pre_stall_x7"}, dut.regs[7], stall_x7);
        EN = 1'b0;
        repeat (stall_len) @(posedge CLK);
        #1;
        check({name, ".post_stall_pc"}, dut.pc, stall_pc);
        check({name, ".post_stall_x7"}, dut.regs[7], stall_x7);
        EN = 1'b1;
        stalled = 1;
      end
      @(posedge CLK);
      #1;
      edges++;
    end
    last_edges = edges;
    check({name, ".ddr_rstn_released"}, 32'(ddr3_reset_n), 32'd1);
    check({name, ".ck_follows"}, {30'd0, ddr3_ck_p, ddr3_ck_n}, {30'd0, CLK, ~CLK});
    EN = 1'b0; START = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ALU program
    prog.delete();
    prog.push_back(enc_i(5, 0, 0, 1, 'h13));        // 0  addi x1,x0,5
    prog.push_back(enc_i(-3, 0, 0, 2, 'h13));       // 4  addi x2,x0,-3
    prog.push_back(enc_r(0, 2, 1, 0, 3, 'h33));     // 8  add  x3,x1,x2
    prog.push_back(enc_r(0, 1, 2, 2, 4, 'h33));     // 12 slt  x4,x2,x1
    prog.push_back(enc_i('h401, 2, 5, 5, 'h13));    // 16 srai x5,x2,1
    prog.push_back(32'h0000_006F);                  // 20 halt
    load_prog();
    do_reset("alu");
    expect_val("alu.x1", K_REG, 1, 32'd5);
    expect_val("alu.x2", K_REG, 2, 32'hFFFF_FFFD);
    expect_val("alu.x3", K_REG, 3, 32'd2);
    expect_val("alu.x4", K_REG, 4, 32'd1);
    expect_val("alu.x5", K_REG, 5, 32'hFFFF_FFFE);
    expect_val("alu.pc", K_PC, 0, 32'd20);
    expect_val("alu.ok", K_OK, 0, 32'd1);
    expect_val("alu.edges", K_EDGES, 0, 32'd6);
    run("alu", 200, -1, 0, 32'd0, 32'd0);
    drain();

    // Memory program
    prog.delete();
    prog.push_back(enc_u('h10010, 8, 'h37));        // 0  lui  x8,0x10010
    prog.push_back(enc_i(7, 0, 0, 9, 'h13));        // 4  addi x9,x0,7
    prog.push_back(enc_i(0, 8, 2, 6, 'h03));        // 8  lw   x6,0(x8)
    prog.push_back(enc_s(4, 6, 8, 2));              // 12 sw   x6,4(x8)
    prog.push_back(enc_s(-4, 6, 8, 2));             // 16 sw   x6,-4(x8)  below base: dropped
    prog.push_back(enc_i(0, 0, 2, 9, 'h03));        // 20 lw   x9,0(x0)   out of range: 0
    prog.push_back(enc_i(4, 8, 2, 10, 'h03));       // 24 lw   x10,4(x8)
    prog.push_back(32'h0000_0073);                  // 28 ecall
    load_prog();
    dut.dmem[0]    = 32'h0000_1234;
    dut.dmem[1]    = 32'h0000_0000;
    dut.dmem[1023] = 32'h0000_A5A5;
    do_reset("mem");
    expect_val("mem.x6", K_REG, 6, 32'h1234);
    expect_val("mem.ram1", K_MEM, 1, 32'h1234);
    expect_val("mem.ram_last_kept", K_MEM, 1023, 32'hA5A5);
    expect_val("mem.x9_oor_load", K_REG, 9, 32'd0);
    expect_val("mem.x10", K_REG, 10, 32'h1234);
    expect_val("mem.pc", K_PC, 0, 32'd28);
    expect_val("mem.edges", K_EDGES, 0, 32'd8);
    run("mem", 200, -1, 0, 32'd0, 32'd0);
    drain();
    do_reset("memkeep");
    check("memkeep.ram1_after_reset", dut.dmem[1], 32'h1234);

    // Control-flow program, then the same program with an EN=0 gap mid-loop
    prog.delete();
    prog.push_back(enc_i(10, 0, 0, 7, 'h13));       // 0  addi x7,x0,10
    prog.push_back(enc_i(-1, 7, 0, 7, 'h13));       // 4  addi x7,x7,-1
    prog.push_back(enc_b(-4, 0, 7, 1));             // 8  bne  x7,x0,-4
    prog.push_back(enc_j(12, 1));                   // 12 jal  x1,+12
    prog.push_back(enc_i('h55, 0, 0, 11, 'h13));    // 16 addi x11,x0,0x55
    prog.push_back(enc_j(16, 0));                   // 20 jal  x0,+16
    prog.push_back(enc_i('h66, 0, 0, 12, 'h13));    // 24 addi x12,x0,0x66
    prog.push_back(enc_i(1, 1, 0, 13, 'h67));       // 28 jalr x13,1(x1)
    prog.push_back(enc_i(1, 0, 0, 14, 'h13));       // 32 addi x14,x0,1 (skipped)
    prog.push_back(32'h0000_006F);                  // 36 halt
    load_prog();
    for (int pass = 0; pass < 2; pass++) begin
      string n;
      n = (pass == 0) ? "cf" : "cfstall";
      do_reset(n);
      expect_val({n, ".x7"}, K_REG, 7, 32'd0);
      expect_val({n, ".x1_ra"}, K_REG, 1, 32'd16);
      expect_val({n, ".x11"}, K_REG, 11, 32'h55);
      expect_val({n, ".x12"}, K_REG, 12, 32'h66);
      expect_val({n, ".x13_ra"}, K_REG, 13, 32'd32);
      expect_val({n, ".x14_skipped"}, K_REG, 14, 32'd0);
      expect_val({n, ".pc"}, K_PC, 0, 32'd36);
      expect_val({n, ".edges"}, K_EDGES, 0, 32'd27);
      if (pass == 0) run(n, 300, -1, 0, 32'd0, 32'd0);
      else           run(n, 300, 7, 5, 32'd4, 32'd7);
      drain();
    end

    // Edge cases: x0 write, unsupported opcode, signed branches, misc ALU; run twice
    prog.delete();
    prog.push_back(enc_i(9, 0, 0, 0, 'h13));        // 0  addi x0,x0,9
    prog.push_back(enc_i(5, 0, 0, 15, 'h7B));       // 4  unsupported opcode
    prog.push_back(enc_i(-1, 0, 0, 1, 'h13));       // 8  addi x1,x0,-1
    prog.push_back(enc_i(1, 0, 0, 2, 'h13));        // 12 addi x2,x0,1
    prog.push_back(enc_b(8, 2, 1, 4));              // 16 blt  x1,x2,+8 (taken)
    prog.push_back(enc_i(1, 0, 0, 3, 'h13));        // 20 addi x3,x0,1
    prog.push_back(enc_b(8, 1, 2, 5));              // 24 bge  x2,x1,+8 (taken)
    prog.push_back(enc_i(2, 0, 0, 3, 'h13));        // 28 addi x3,x0,2
    prog.push_back(enc_b(8, 2, 1, 0));              // 32 beq  x1,x2,+8 (not taken)
    prog.push_back(enc_r(0, 2, 1, 4, 4, 'h33));     // 36 xor  x4,x1,x2
    prog.push_back(enc_r(0, 2, 1, 5, 5, 'h33));     // 40 srl  x5,x1,x2
    prog.push_back(enc_r(32, 1, 2, 0, 6, 'h33));    // 44 sub  x6,x2,x1
    prog.push_back(enc_u(1, 7, 'h17));              // 48 auipc x7,1
    prog.push_back(32'h0000_006F);                  // 52 halt
    load_prog();
    for (int pass = 0; pass < 2; pass++) begin
      string n;
      n = (pass == 0) ? "edge" : "rerun";
      do_reset(n);
      expect_val({n, ".x0"}, K_REG, 0, 32'd0);
      expect_val({n, ".x15_nop"}, K_REG, 15, 32'd0);
      expect_val({n, ".x3_skipped"}, K_REG, 3, 32'd0);
      expect_val({n, ".x4_xor"}, K_REG, 4, 32'hFFFF_FFFE);
      expect_val({n, ".x5_srl"}, K_REG, 5, 32'h7FFF_FFFF);
      expect_val({n, ".x6_sub"}, K_REG, 6, 32'd2);
      expect_val({n, ".x7_auipc"}, K_REG, 7, 32'h0000_1030);
      expect_val({n, ".pc"}, K_PC, 0, 32'd52);
      expect_val({n, ".ok"}, K_OK, 0, 32'd1);
      expect_val({n, ".edges"}, K_EDGES, 0, 32'd12);
      run(n, 200, -1, 0, 32'd0, 32'd0);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
